// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered RV32IM immediate generator behind a 2-entry skid buffer
module imm_gen_stage #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ins,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_ins,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [31:0]     ins;
    logic [PC_W-1:0] pc;
    logic [31:0]     imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_X = 3'd7;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   in_ready_q, in_ready_d;
  entry_t new_e;
  logic   accept;
  logic   pop;

  // Decode happens on the incoming word so the stored entry is already complete.
  always_comb begin
    new_e         = '0;
    new_e.ins     = in_ins;
    new_e.pc      = in_pc;
    case (in_ins[6:0])
      7'b0110011: begin
        new_e.fmt = FMT_R;
        new_e.imm = 32'd0;
      end
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        new_e.fmt = FMT_I;
        new_e.imm = {{20{in_ins[31]}}, in_ins[31:20]};
      end
      7'b0100011: begin
        new_e.fmt = FMT_S;
        new_e.imm = {{20{in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
      end
      7'b1100011: begin
        new_e.fmt = FMT_B;
        new_e.imm = {{19{in_ins[31]}}, in_ins[31], in_ins[7], in_ins[30:25],
                     in_ins[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        new_e.fmt = FMT_U;
        new_e.imm = {in_ins[31:12], 12'b0};
      end
      7'b1101111: begin
        new_e.fmt = FMT_J;
        new_e.imm = {{11{in_ins[31]}}, in_ins[31], in_ins[19:12], in_ins[20],
                     in_ins[30:21], 1'b0};
      end
      default: begin
        new_e.fmt     = FMT_X;
        new_e.illegal = 1'b1;
        new_e.imm     = 32'd0;
      end
    endcase
  end

  assign accept = in_valid && in_ready_q;
  assign pop    = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    if (flush) begin
      // Redirect: drop both entries and whatever is being offered this cycle.
      state_d     = EMPTY;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
      skid_d      = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d      = new_e;
            out_valid_d = 1'b1;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = new_e;
          end else if (accept) begin
            skid_d     = new_e;
            in_ready_d = 1'b0;
            state_d    = FULL;
          end else if (pop) begin
            out_valid_d = 1'b0;
            state_d     = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_d     = skid_q;
            in_ready_d = 1'b1;
            state_d    = ONE;
          end
        end
        default: begin
          state_d     = EMPTY;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_ins     = main_q.ins;
  assign out_pc      = main_q.pc;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - directed vector bench for imm_gen_stage
module tb_imm_gen_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ins;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  vec_t vecs[12];

  imm_gen_stage #(.PC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ins      (in_ins),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ins     (out_ins),
    .out_pc      (out_pc),
    .out_imm     (out_imm),
    .out_fmt     (out_fmt),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'h001000EF, 32'h00000800, 3'd5, 1'b0};
    vecs[1]  = '{32'hFFDFF0EF, 32'hFFFFFFFC, 3'd5, 1'b0};
    vecs[2]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0};
    vecs[3]  = '{32'h0020A423, 32'h00000008, 3'd2, 1'b0};
    vecs[4]  = '{32'h123450B7, 32'h12345000, 3'd4, 1'b0};
    vecs[5]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0};
    vecs[6]  = '{32'h0000007F, 32'h00000000, 3'd7, 1'b1};
    vecs[7]  = '{32'h00B50533, 32'h00000000, 3'd0, 1'b0};
    vecs[8]  = '{32'h7FF00013, 32'h000007FF, 3'd1, 1'b0};
    vecs[9]  = '{32'h80000037, 32'h80000000, 3'd4, 1'b0};
    vecs[10] = '{32'h00000073, 32'h00000000, 3'd1, 1'b0};
    vecs[11] = '{32'hFFFFFFFF, 32'h00000000, 3'd7, 1'b1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ins = '0; in_pc = '0; out_ready = 1'b0;
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_imm", out_imm, 32'd0);
    check("rst_out_fmt", 32'(out_fmt), 32'd0);
    check("rst_out_illegal", 32'(out_illegal), 32'd0);
    rst = 1'b0;

    // Back-to-back stream with the consumer always ready.
    for (int i = 0; i < 12; i++) begin
      in_valid  = 1'b1;
      in_ins    = vecs[i].ins;
      in_pc     = 32'h1000 + 32'(i * 4);
      out_ready = 1'b1;
      step();
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d_ins", i), out_ins, vecs[i].ins);
      check($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(i * 4));
      check($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
      check($sformatf("v%0d_fmt", i), 32'(out_fmt), 32'(vecs[i].fmt));
      check($sformatf("v%0d_ill", i), 32'(out_illegal), 32'(vecs[i].ill));
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // Backpressure: A, B accepted, C held off until space frees.
    out_ready = 1'b0;
    in_valid  = 1'b1; in_ins = 32'h001000EF; in_pc = 32'hA0;
    step();
    check("bp_a_valid", 32'(out_valid), 32'd1);
    check("bp_a_in_ready", 32'(in_ready), 32'd1);
    in_ins = 32'hFFF00093; in_pc = 32'hB0;
    step();
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    check("bp_full_out_ins", out_ins, 32'h001000EF);
    in_ins = 32'h0020A423; in_pc = 32'hC0;
    step();
    check("bp_hold_out_ins", out_ins, 32'h001000EF);
    check("bp_hold_out_imm", out_imm, 32'h00000800);
    check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    check("bp_b_ins", out_ins, 32'hFFF00093);
    check("bp_b_imm", out_imm, 32'hFFFFFFFF);
    check("bp_b_in_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_c_ins", out_ins, 32'h0020A423);
    check("bp_c_pc", out_pc, 32'hC0);
    check("bp_c_imm", out_imm, 32'h00000008);
    in_valid = 1'b0;
    step();
    check("bp_empty_valid", 32'(out_valid), 32'd0);

    // Flush while FULL with a new input offered in the same cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1; in_ins = 32'h123450B7; in_pc = 32'hD0;
    step();
    in_ins = 32'hFE000EE3; in_pc = 32'hE0;
    step();
    check("fl_full_in_ready", 32'(in_ready), 32'd0);
    flush = 1'b1; in_ins = 32'h00B50533; in_pc = 32'hF0;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("fl_quiet%0d", i), 32'(out_valid), 32'd0);
    end

    // Reset while ONE discards the entry.
    out_ready = 1'b0;
    in_valid  = 1'b1; in_ins = 32'hFFDFF0EF; in_pc = 32'h1234;
    step();
    in_valid = 1'b0;
    check("rs_one_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rs_out_valid", 32'(out_valid), 32'd0);
    check("rs_in_ready", 32'(in_ready), 32'd1);
    check("rs_out_ins", out_ins, 32'd0);
    check("rs_out_pc", out_pc, 32'd0);
    check("rs_out_imm", out_imm, 32'd0);
    check("rs_out_fmt", 32'(out_fmt), 32'd0);
    check("rs_out_ill", 32'(out_illegal), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
